// File: rtl/eth_pkg.sv
// Shared definitions for the RMII game-link receiver and its transmitter counterpart.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, HEADER, PAYLOAD, FCS, CHECK, WAIT_IDLE, DROP
  } rx_state_t;

  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int          HDR_BYTES     = 14;
  localparam int          FCS_BYTES     = 4;
  localparam int          GAME_BYTES    = 6;

  // Bit positions of the game fields inside the first six payload bytes (byte 0 at MSB)
  localparam int X_LSB    = 37;
  localparam int Y_LSB    = 25;
  localparam int DIR_LSB  = 15;
  localparam int STAT_LSB = 9;
  localparam int PRST_BIT = 7;

  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic d);
    return (c >> 1) ^ ((c[0] ^ d) ? CRC_POLY_REFL : 32'h0);
  endfunction

  // Byte idx of a MAC in wire order (byte 0 is the most significant)
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] s;
    s = mac << {idx, 3'b000};
    return s[47:40];
  endfunction

endpackage

// File: rtl/ether_receive_if.sv
// RMII receive pins plus the decoded opponent-state outputs of the game-link receiver.
interface ether_receive_if;
  logic        eth_crsdv;
  logic [1:0]  eth_rxd;
  logic [10:0] rx_player_x;
  logic [10:0] rx_player_y;
  logic [8:0]  rx_direction;
  logic [2:0]  rx_game_stat;
  logic        rx_peer_rst;
  logic        rx_valid;
  logic        rx_err;

  modport master (output eth_crsdv, eth_rxd,
                  input  rx_player_x, rx_player_y, rx_direction, rx_game_stat,
                         rx_peer_rst, rx_valid, rx_err);
  modport slave  (input  eth_crsdv, eth_rxd,
                  output rx_player_x, rx_player_y, rx_direction, rx_game_stat,
                         rx_peer_rst, rx_valid, rx_err);
endinterface

// File: rtl/ether_receive_crc32_dibit.sv
// Ethernet CRC-32 (reflected, never inverted) advanced two bits per clock, LSB first.
module crc32_dibit
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [1:0]  din,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    crc <= CRC_INIT;
    else if (init) crc <= CRC_INIT;
    else if (en)   crc <= crc_bit(crc_bit(crc, din[0]), din[1]);
  end

endmodule

// File: rtl/ether_receive.sv
// RMII frame receiver: deframes, filters on destination MAC, checks FCS and unpacks game state.
// state     | meaning
// IDLE      | waiting for carrier and a preamble dibit
// PREAMBLE  | counting 01 dibits, waiting for the SFD tail
// HEADER    | dest MAC (filtered), source, length
// PAYLOAD   | game bytes into shadow, rest discarded
// FCS       | four CRC bytes
// CHECK     | residue test, commit or error
// WAIT_IDLE | frame done, waiting for carrier drop
// DROP      | address mismatch, waiting silently for carrier drop
module ether_receive
  import eth_pkg::*;
#(
  parameter logic [47:0] MY_MAC        = 48'h02_00_00_00_00_01,
  parameter int          PAYLOAD_BYTES = 38,
  parameter int          MIN_PREAMBLE  = 8,
  parameter bit          CHECK_FCS     = 1'b1
) (
  input  logic     eth_clk,
  input  logic     eth_rst_n,
  ether_receive_if.slave rx
);

  localparam logic [4:0] MIN_PRE  = 5'(MIN_PREAMBLE);
  localparam logic [5:0] MAC_LAST = 6'd5;
  localparam logic [5:0] HDR_LAST = 6'(HDR_BYTES - 1);
  localparam logic [5:0] PAY_LAST = 6'(PAYLOAD_BYTES - 1);
  localparam logic [5:0] FCS_LAST = 6'(FCS_BYTES - 1);
  localparam logic [5:0] GAME_N   = 6'(GAME_BYTES);

  rx_state_t   state, state_nxt;
  logic [4:0]  pre_cnt, pre_cnt_nxt;
  logic [5:0]  byte_cnt;
  logic [1:0]  dib_cnt;
  logic [5:0]  byte_sr;
  logic [47:0] shadow;
  logic        mac_my, mac_bc;
  logic [31:0] crc;
  logic [7:0]  byte_full;
  logic        byte_done, data_en, my_hit, bc_hit;
  logic        frame_clr, cnt_clr, commit, err_nxt;

  assign byte_full = {rx.eth_rxd, byte_sr};
  assign byte_done = rx.eth_crsdv && (dib_cnt == 2'd3);
  assign data_en   = rx.eth_crsdv && (state inside {HEADER, PAYLOAD, FCS});
  assign my_hit    = mac_my && (byte_full == mac_byte(MY_MAC, byte_cnt[2:0]));
  assign bc_hit    = mac_bc && (byte_full == mac_byte(BCAST_MAC, byte_cnt[2:0]));

  crc32_dibit u_crc (
    .clk  (eth_clk),
    .rst_n(eth_rst_n),
    .init (frame_clr),
    .en   (data_en),
    .din  (rx.eth_rxd),
    .crc  (crc)
  );

  always_comb begin
    state_nxt   = state;
    pre_cnt_nxt = pre_cnt;
    frame_clr   = 1'b0;
    cnt_clr     = 1'b0;
    commit      = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE:
        if (rx.eth_crsdv && rx.eth_rxd == SFD_BYTE[1:0]) begin
          state_nxt   = PREAMBLE;
          pre_cnt_nxt = 5'd1;
        end
      PREAMBLE:
        if (!rx.eth_crsdv) state_nxt = IDLE;
        else if (rx.eth_rxd == SFD_BYTE[1:0])
          pre_cnt_nxt = (pre_cnt == 5'd31) ? pre_cnt : pre_cnt + 5'd1;
        else if (rx.eth_rxd == SFD_BYTE[7:6] && pre_cnt >= MIN_PRE) begin
          state_nxt = HEADER;
          frame_clr = 1'b1;
        end else state_nxt = IDLE;
      HEADER:
        if (!rx.eth_crsdv) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (byte_done) begin
          if (byte_cnt == MAC_LAST && !(my_hit || bc_hit)) state_nxt = DROP;
          else if (byte_cnt == HDR_LAST) begin
            state_nxt = PAYLOAD;
            cnt_clr   = 1'b1;
          end
        end
      PAYLOAD:
        if (!rx.eth_crsdv) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (byte_done && byte_cnt == PAY_LAST) begin
          state_nxt = FCS;
          cnt_clr   = 1'b1;
        end
      FCS:
        if (!rx.eth_crsdv) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (byte_done && byte_cnt == FCS_LAST) state_nxt = CHECK;
      CHECK: begin
        if (!CHECK_FCS || crc == CRC_RESIDUE) commit = 1'b1;
        else err_nxt = 1'b1;
        state_nxt = WAIT_IDLE;
      end
      WAIT_IDLE, DROP:
        if (!rx.eth_crsdv) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state           <= IDLE;
      pre_cnt         <= '0;
      byte_cnt        <= '0;
      dib_cnt         <= '0;
      byte_sr         <= '0;
      shadow          <= '0;
      mac_my          <= 1'b0;
      mac_bc          <= 1'b0;
      rx.rx_player_x  <= '0;
      rx.rx_player_y  <= '0;
      rx.rx_direction <= '0;
      rx.rx_game_stat <= '0;
      rx.rx_peer_rst  <= 1'b0;
      rx.rx_valid     <= 1'b0;
      rx.rx_err       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pre_cnt     <= pre_cnt_nxt;
      rx.rx_valid <= commit;
      rx.rx_err   <= err_nxt;
      if (frame_clr) begin
        byte_cnt <= '0;
        dib_cnt  <= '0;
        mac_my   <= 1'b1;
        mac_bc   <= 1'b1;
      end else if (data_en) begin
        byte_sr <= {rx.eth_rxd, byte_sr[5:2]};
        dib_cnt <= dib_cnt + 2'd1;
        if (dib_cnt == 2'd3) begin
          byte_cnt <= cnt_clr ? 6'd0 : byte_cnt + 6'd1;
          if (state == HEADER && byte_cnt <= MAC_LAST) begin
            mac_my <= my_hit;
            mac_bc <= bc_hit;
          end
          if (state == PAYLOAD && byte_cnt < GAME_N) shadow <= {shadow[39:0], byte_full};
        end
      end
      if (commit) begin
        rx.rx_player_x  <= shadow[X_LSB +: 11];
        rx.rx_player_y  <= shadow[Y_LSB +: 11];
        rx.rx_direction <= shadow[DIR_LSB +: 9];
        rx.rx_game_stat <= shadow[STAT_LSB +: 3];
        rx.rx_peer_rst  <= shadow[PRST_BIT];
      end
    end
  end

endmodule

// File: tb/tb_ether_receive.sv
// Scoreboard bench for ether_receive: one FCS-checking and one FCS-ignoring copy on the same wire.
module tb_ether_receive;
  import eth_pkg::*;

  typedef struct {
    bit          is_err;
    logic [10:0] x;
    logic [10:0] y;
    logic [8:0]  dir;
    logic [2:0]  stat;
    logic        prst;
    int          lat;
  } exp_t;

  localparam logic [47:0] T_MY    = 48'h0200_0000_0001;
  localparam logic [47:0] T_OTHER = 48'h0200_0000_0002;
  localparam logic [47:0] T_BCAST = 48'hFFFF_FFFF_FFFF;

  logic eth_clk = 1'b0;
  logic eth_rst_n = 1'b0;
  always #10 eth_clk = ~eth_clk;

  ether_receive_if rx1 ();
  ether_receive_if rx0 ();
  assign rx0.eth_crsdv = rx1.eth_crsdv;
  assign rx0.eth_rxd   = rx1.eth_rxd;

  ether_receive #(.CHECK_FCS(1'b1)) dut1 (.eth_clk(eth_clk), .eth_rst_n(eth_rst_n), .rx(rx1));
  ether_receive #(.CHECK_FCS(1'b0)) dut0 (.eth_clk(eth_clk), .eth_rst_n(eth_rst_n), .rx(rx0));

  exp_t       sb[$];
  exp_t       hold, mon_e, f;
  logic [7:0] frm[$];
  int n_chk = 0, n_fail = 0;
  int cyc = 0, last_cyc = 0;
  int v0_cnt = 0, e0_cnt = 0, v0_exp = 0, e0_exp = 0;

  always @(posedge eth_clk) cyc++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge eth_clk) begin
    if (eth_rst_n) begin
      if (rx0.rx_valid) v0_cnt++;
      if (rx0.rx_err)   e0_cnt++;
      if (rx1.rx_valid || rx1.rx_err) begin
        check_eq("valid_err_mutex", rx1.rx_valid & rx1.rx_err, 0);
        check_eq("sb_pending", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check_eq("pulse_kind_err", rx1.rx_err, mon_e.is_err);
          check_eq("pulse_latency_ok", (cyc - last_cyc) <= mon_e.lat && (cyc - last_cyc) >= 0, 1);
          check_eq("out_x",    rx1.rx_player_x,  mon_e.x);
          check_eq("out_y",    rx1.rx_player_y,  mon_e.y);
          check_eq("out_dir",  rx1.rx_direction, mon_e.dir);
          check_eq("out_stat", rx1.rx_game_stat, mon_e.stat);
          check_eq("out_prst", rx1.rx_peer_rst,  mon_e.prst);
          if (!mon_e.is_err) hold = mon_e;
        end
      end
    end
  end

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic build(input logic [47:0] dest, input exp_t fe, input int flip_byte);
    logic [47:0] sh, src;
    logic [31:0] c;
    frm.delete();
    src = 48'h0200_0000_0009;
    sh = '0;
    sh[47:37] = fe.x;
    sh[35:25] = fe.y;
    sh[23:15] = fe.dir;
    sh[11:9]  = fe.stat;
    sh[7]     = fe.prst;
    for (int i = 0; i < 6; i++) frm.push_back(dest[47 - 8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(src[47 - 8*i -: 8]);
    frm.push_back(8'h00);
    frm.push_back(8'h26);
    for (int i = 0; i < 6; i++) frm.push_back(sh[47 - 8*i -: 8]);
    for (int i = 6; i < 38; i++) frm.push_back(8'(i));
    c = 32'hFFFF_FFFF;
    foreach (frm[i]) c = crc_byte(c, frm[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    if (flip_byte >= 0) frm[flip_byte] = frm[flip_byte] ^ 8'h10;
  endtask

  task automatic drive(input logic v, input logic [1:0] d);
    @(negedge eth_clk);
    rx1.eth_crsdv = v;
    rx1.eth_rxd   = d;
  endtask

  task automatic check_hold(input string tag);
    check_eq({tag, "_x"},    rx1.rx_player_x,  hold.x);
    check_eq({tag, "_y"},    rx1.rx_player_y,  hold.y);
    check_eq({tag, "_dir"},  rx1.rx_direction, hold.dir);
    check_eq({tag, "_stat"}, rx1.rx_game_stat, hold.stat);
    check_eq({tag, "_prst"}, rx1.rx_peer_rst,  hold.prst);
  endtask

  // stop_at: byte index where carrier drops (abort); rst_at: byte index where reset is pulsed
  task automatic send(input int pre, input int stop_at, input int rst_at);
    logic [7:0] b;
    int n;
    bit reset_done;
    reset_done = 0;
    for (int i = 0; i < pre; i++) drive(1'b1, 2'b01);
    b = 8'hD5;
    for (int d = 0; d < 4; d++) drive(1'b1, b[2*d +: 2]);
    n = (stop_at >= 0) ? stop_at : frm.size();
    for (int i = 0; i < n && !reset_done; i++) begin
      if (i == rst_at) begin
        @(negedge eth_clk);
        eth_rst_n = 1'b0;
        rx1.eth_crsdv = 1'b0;
        #1;
        hold.x = 0; hold.y = 0; hold.dir = 0; hold.stat = 0; hold.prst = 0;
        check_hold("rst_async");
        check_eq("rst_valid", rx1.rx_valid, 0);
        check_eq("rst_err", rx1.rx_err, 0);
        repeat (2) @(negedge eth_clk);
        eth_rst_n = 1'b1;
        reset_done = 1;
      end else begin
        b = frm[i];
        for (int d = 0; d < 4; d++) drive(1'b1, b[2*d +: 2]);
      end
    end
    if (!reset_done) begin
      if (stop_at >= 0) begin
        drive(1'b0, 2'b00);
        last_cyc = cyc + 1;
        @(negedge eth_clk);
        check_eq("abort_state_idle", dut1.state, IDLE);
      end else last_cyc = cyc + 1;
    end
    repeat (8) drive(1'b0, 2'b00);
    check_eq("sb_drain", sb.size(), 0);
  endtask

  function automatic exp_t mk(input bit e, input int x, input int y, input int dir,
                              input int stat, input int prst, input int lat);
    exp_t r;
    r.is_err = e; r.x = 11'(x); r.y = 11'(y); r.dir = 9'(dir);
    r.stat = 3'(stat); r.prst = 1'(prst); r.lat = lat;
    return r;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rx1.eth_crsdv = 1'b0;
    rx1.eth_rxd   = 2'b00;
    hold = mk(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge eth_clk);
    check_hold("reset");
    check_eq("reset_valid", rx1.rx_valid, 0);
    check_eq("reset_err", rx1.rx_err, 0);
    check_eq("reset_crc", dut1.u_crc.crc, 32'hFFFF_FFFF);
    check_eq("reset_state", dut1.state, IDLE);
    eth_rst_n = 1'b1;
    repeat (2) @(negedge eth_clk);

    // Good broadcast frame
    f = mk(0, 300, 200, 90, 2, 0, 2);
    build(T_BCAST, f, -1);
    sb.push_back(f); v0_exp++;
    send(28, -1, -1);
    check_hold("t1_hold");

    // Payload bit flip: error on the checking copy, accepted by the non-checking copy
    f = mk(0, 300, 200, 90, 2, 0, 2);
    build(T_BCAST, f, 14 + 10);
    e = hold; e.is_err = 1; e.lat = 2;
    sb.push_back(e); v0_exp++;
    send(28, -1, -1);
    check_hold("t2_hold");
    check_eq("t2_dut0_valid", v0_cnt, v0_exp);

    // Carrier drop after 20 payload bytes, then a good unicast frame
    f = mk(0, 17, 33, 44, 3, 1, 2);
    build(T_MY, f, -1);
    e = hold; e.is_err = 1; e.lat = 0;
    sb.push_back(e); e0_exp++;
    send(28, 14 + 20, -1);
    check_hold("t3_hold");
    f = mk(0, 5, 7, 270, 5, 1, 2);
    build(T_MY, f, -1);
    sb.push_back(f); v0_exp++;
    send(28, -1, -1);
    check_hold("t3b_hold");

    // Foreign unicast address: silent
    f = mk(0, 1000, 999, 100, 6, 0, 2);
    build(T_OTHER, f, -1);
    send(28, -1, -1);
    check_hold("t4_hold");

    // Short preamble ignored, MIN_PREAMBLE accepted
    f = mk(0, 77, 66, 55, 4, 0, 2);
    build(T_BCAST, f, -1);
    send(4, -1, -1);
    check_hold("t5_hold");
    f = mk(0, 1500, 1023, 511, 7, 1, 2);
    build(T_MY, f, -1);
    sb.push_back(f); v0_exp++;
    send(8, -1, -1);
    check_hold("t5b_hold");

    // Reset mid-payload, then a fresh frame
    f = mk(0, 400, 401, 402, 1, 1, 2);
    build(T_BCAST, f, -1);
    send(28, -1, 14 + 10);
    check_hold("t6_hold");
    f = mk(0, 123, 456, 200, 1, 0, 2);
    build(T_BCAST, f, -1);
    sb.push_back(f); v0_exp++;
    send(28, -1, -1);
    check_hold("t6b_hold");

    check_eq("dut0_valid_count", v0_cnt, v0_exp);
    check_eq("dut0_err_count", e0_cnt, e0_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
